// File: rtl/butterfly3.sv
// -----------------------------------------------------------------------------
// butterfly3 - third and final radix-2 stage of the 8-point DIT FFT datapath.
//
// The block takes the eight stage-2 points d1..d8 and applies the W8 twiddles
// W0..W3 to the lower half d5..d8. It then forms the final add/subtract pairs
// (1,5) (2,6) (3,7) (4,8), which leave the block in natural order.
//
// The pipeline has two register stages, with no backpressure:
//   stage A : holds d1..d4 as they arrive, plus the twiddled t5..t8, and vA.
//   stage B : holds the x1..x8 sums and differences, the ready pulse and the
//             frame counter.
//
// Ports
//   clk                         rising-edge clock
//   rst_n                       asynchronous reset, active low
//   butterfly2_ready            input frame valid (one pulse per frame)
//   fft_dK_real/imag  (K=1..8)  signed stage-2 results, `instWidth bits
//   fft_xK_real/imag_o(K=1..8)  registered FFT outputs, `instWidth bits
//   butterfly3_ready            one-cycle output valid pulse per frame
//   fft_frame_cnt               completed-frame counter, wraps 255 -> 0
//
// Configuration
//   BUTTERFLY3_ROUND_EN  When this is defined, the t6/t8 twiddle products use
//                        round-half-up, (v + 128) >>> 8. When it is undefined,
//                        they use floor, v >>> 8. Latency and interface are
//                        the same in both builds.
// -----------------------------------------------------------------------------
`ifndef instWidth
`define instWidth 32
`endif

module butterfly3 (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          butterfly2_ready,
  input  logic signed [`instWidth-1:0]  fft_d1_real,
  input  logic signed [`instWidth-1:0]  fft_d1_imag,
  input  logic signed [`instWidth-1:0]  fft_d2_real,
  input  logic signed [`instWidth-1:0]  fft_d2_imag,
  input  logic signed [`instWidth-1:0]  fft_d3_real,
  input  logic signed [`instWidth-1:0]  fft_d3_imag,
  input  logic signed [`instWidth-1:0]  fft_d4_real,
  input  logic signed [`instWidth-1:0]  fft_d4_imag,
  input  logic signed [`instWidth-1:0]  fft_d5_real,
  input  logic signed [`instWidth-1:0]  fft_d5_imag,
  input  logic signed [`instWidth-1:0]  fft_d6_real,
  input  logic signed [`instWidth-1:0]  fft_d6_imag,
  input  logic signed [`instWidth-1:0]  fft_d7_real,
  input  logic signed [`instWidth-1:0]  fft_d7_imag,
  input  logic signed [`instWidth-1:0]  fft_d8_real,
  input  logic signed [`instWidth-1:0]  fft_d8_imag,
  output logic signed [`instWidth-1:0]  fft_x1_real_o,
  output logic signed [`instWidth-1:0]  fft_x1_imag_o,
  output logic signed [`instWidth-1:0]  fft_x2_real_o,
  output logic signed [`instWidth-1:0]  fft_x2_imag_o,
  output logic signed [`instWidth-1:0]  fft_x3_real_o,
  output logic signed [`instWidth-1:0]  fft_x3_imag_o,
  output logic signed [`instWidth-1:0]  fft_x4_real_o,
  output logic signed [`instWidth-1:0]  fft_x4_imag_o,
  output logic signed [`instWidth-1:0]  fft_x5_real_o,
  output logic signed [`instWidth-1:0]  fft_x5_imag_o,
  output logic signed [`instWidth-1:0]  fft_x6_real_o,
  output logic signed [`instWidth-1:0]  fft_x6_imag_o,
  output logic signed [`instWidth-1:0]  fft_x7_real_o,
  output logic signed [`instWidth-1:0]  fft_x7_imag_o,
  output logic signed [`instWidth-1:0]  fft_x8_real_o,
  output logic signed [`instWidth-1:0]  fft_x8_imag_o,
  output logic                          butterfly3_ready,
  output logic [7:0]                    fft_frame_cnt
);

  localparam int W     = `instWidth;
  localparam int PW    = W + 10;   // width of the twiddle product
  localparam int TW_Q8 = 181;      // 1/sqrt(2) in Q8

  typedef logic signed [W-1:0] samp_t;

  // Gather the inputs into arrays. Index 0 is d1.
  samp_t d_re [8];
  samp_t d_im [8];

  assign d_re[0] = fft_d1_real;  assign d_im[0] = fft_d1_imag;
  assign d_re[1] = fft_d2_real;  assign d_im[1] = fft_d2_imag;
  assign d_re[2] = fft_d3_real;  assign d_im[2] = fft_d3_imag;
  assign d_re[3] = fft_d4_real;  assign d_im[3] = fft_d4_imag;
  assign d_re[4] = fft_d5_real;  assign d_im[4] = fft_d5_imag;
  assign d_re[5] = fft_d6_real;  assign d_im[5] = fft_d6_imag;
  assign d_re[6] = fft_d7_real;  assign d_im[6] = fft_d7_imag;
  assign d_re[7] = fft_d8_real;  assign d_im[7] = fft_d8_imag;

  // Stage A state. Entries 0..3 hold d1..d4 and entries 4..7 hold t5..t8.
  samp_t a_re_q [8];
  samp_t a_im_q [8];
  samp_t a_re_d [8];
  samp_t a_im_d [8];
  logic  va_q, va_d;

  // Stage B state. Entry k holds x(k+1).
  samp_t x_re_q [8];
  samp_t x_im_q [8];
  samp_t x_re_d [8];
  samp_t x_im_d [8];
  logic       rdy_q, rdy_d;
  logic [7:0] cnt_q, cnt_d;

  // Multiply a W+1 bit sum by 1/sqrt(2) in Q8. The product needs PW bits, so
  // it cannot overflow.
  function automatic logic signed [PW-1:0] mul_tw(input logic signed [W:0] s);
    return PW'(s) * PW'(TW_Q8);
  endfunction

  // Drop the Q8 fraction. Negative values floor toward -inf; they do not
  // truncate toward zero.
  function automatic samp_t sh(input logic signed [PW-1:0] v);
`ifdef BUTTERFLY3_ROUND_EN
    logic signed [PW-1:0] v_rnd;
    v_rnd = v + PW'(128);
    return W'(v_rnd >>> 8);
`else
    return W'(v >>> 8);
`endif
  endfunction

  // Form the r+i and i-r terms one bit wider than a sample, so they never
  // overflow.
  logic signed [W:0] s6_sum, s6_dif, s8_sum, s8_dif;

  assign s6_sum = (W+1)'(d_re[5]) + (W+1)'(d_im[5]);
  assign s6_dif = (W+1)'(d_im[5]) - (W+1)'(d_re[5]);
  assign s8_sum = (W+1)'(d_re[7]) + (W+1)'(d_im[7]);
  assign s8_dif = (W+1)'(d_im[7]) - (W+1)'(d_re[7]);

  // Stage A: capture the upper half and twiddle the lower half.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      a_re_d[k] = a_re_q[k];
      a_im_d[k] = a_im_q[k];
    end
    va_d = butterfly2_ready;
    if (butterfly2_ready) begin
      // d1..d4 pass straight through, and so does t5 = d5 (W0).
      for (int k = 0; k < 5; k++) begin
        a_re_d[k] = d_re[k];
        a_im_d[k] = d_im[k];
      end
      // t6 = d6 * W1
      a_re_d[5] = sh(mul_tw(s6_sum));
      a_im_d[5] = sh(mul_tw(s6_dif));
      // t7 = -j * d7. This is exact, so no multiply is needed.
      a_re_d[6] = d_im[6];
      a_im_d[6] = -d_re[6];
      // t8 = d8 * W3. Negate before the shift: floor(-v) is not -floor(v).
      a_re_d[7] = sh(mul_tw(s8_dif));
      a_im_d[7] = sh(-mul_tw(s8_sum));
    end
  end

  // Stage B: final butterflies. The sums wrap modulo 2^W.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      x_re_d[k] = x_re_q[k];
      x_im_d[k] = x_im_q[k];
    end
    rdy_d = va_q;
    cnt_d = cnt_q;
    if (va_q) begin
      for (int k = 0; k < 4; k++) begin
        x_re_d[k]     = a_re_q[k] + a_re_q[k+4];
        x_im_d[k]     = a_im_q[k] + a_im_q[k+4];
        x_re_d[k + 4] = a_re_q[k] - a_re_q[k+4];
        x_im_d[k + 4] = a_im_q[k] - a_im_q[k+4];
      end
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        a_re_q[k] <= '0;
        a_im_q[k] <= '0;
        x_re_q[k] <= '0;
        x_im_q[k] <= '0;
      end
      va_q  <= 1'b0;
      rdy_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        a_re_q[k] <= a_re_d[k];
        a_im_q[k] <= a_im_d[k];
        x_re_q[k] <= x_re_d[k];
        x_im_q[k] <= x_im_d[k];
      end
      va_q  <= va_d;
      rdy_q <= rdy_d;
      cnt_q <= cnt_d;
    end
  end

  assign fft_x1_real_o = x_re_q[0];  assign fft_x1_imag_o = x_im_q[0];
  assign fft_x2_real_o = x_re_q[1];  assign fft_x2_imag_o = x_im_q[1];
  assign fft_x3_real_o = x_re_q[2];  assign fft_x3_imag_o = x_im_q[2];
  assign fft_x4_real_o = x_re_q[3];  assign fft_x4_imag_o = x_im_q[3];
  assign fft_x5_real_o = x_re_q[4];  assign fft_x5_imag_o = x_im_q[4];
  assign fft_x6_real_o = x_re_q[5];  assign fft_x6_imag_o = x_im_q[5];
  assign fft_x7_real_o = x_re_q[6];  assign fft_x7_imag_o = x_im_q[6];
  assign fft_x8_real_o = x_re_q[7];  assign fft_x8_imag_o = x_im_q[7];

  assign butterfly3_ready = rdy_q;
  assign fft_frame_cnt    = cnt_q;

endmodule

// File: doc/butterfly3.md
# butterfly3

Third and final radix-2 stage of the 8-point DIT FFT datapath. It consumes the eight complex points produced by `butterfly2` (qualified by `butterfly2_ready`), applies the W8 twiddles to the lower half, and forms the final add/subtract pairs (1,5), (2,6), (3,7), (4,8). It is a 2-cycle pipeline and keeps a frame counter for the RISC-V side to poll. Results go to the FFT result registers/writeback.

## Interface
- `instWidth`: codebase define, 32. Sample component width.
- `TW_Q8`: localparam, 181. Q8 value of 1/√2 (0.7071·256).
- `clk` in 1: Rising-edge clock.
- `rst_n` in 1: Asynchronous reset, active-low.
- `butterfly2_ready` in 1: Input valid, one pulse per frame.
- `fft_dK_real`, `fft_dK_imag` (K=1..8) in `instWidth`, signed: Stage-2 results.
- `fft_xK_real_o`, `fft_xK_imag_o` (K=1..8) out `instWidth`, registered: FFT outputs in natural order.
- `butterfly3_ready` out 1: Output valid, one-cycle pulse per frame.
- `fft_frame_cnt` out 8: Completed frames, wraps.

## Operation
- **Stage A (cycle 1).** On `butterfly2_ready`:
  - Register d1..d4 unchanged.
  - Register the twiddled lower half:
    - t5 = d5 (W0).
    - t6 = d6·W1: re = sh((r+i)·181), im = sh((i−r)·181).
    - t7 = d7·W2 = −j·d7: re = i, im = −r (exact, no multiply).
    - t8 = d8·W3: re = sh((i−r)·181), im = sh(−(r+i)·181).
  - Set `vA`.
- **Stage B (cycle 2).** When `vA` is set:
  - xK = dK + tK+4 and xK+4 = dK − tK+4, for K=1..4.
  - Register all 16 outputs.
  - Pulse `butterfly3_ready`.
  - Increment `fft_frame_cnt`.
- **Arithmetic.**
  - r+i and i−r are formed at `instWidth`+1 bits; products at `instWidth`+10 bits.
  - sh() is an arithmetic right shift by 8 (floor), then truncation to `instWidth`.
  - Final sums wrap modulo 2^`instWidth` (no saturation).
- **Hold behaviour.**
  - Stage-A registers and outputs hold when their valid is low.
  - `butterfly3_ready` is 0 whenever `vA` is 0.
- **No backpressure.** A new frame is accepted every cycle that `butterfly2_ready` is high. Back-to-back frames stream at full rate.
- **Frame counter.** `fft_frame_cnt` wraps 255→0 silently.

## Timing
- **Latency.** `butterfly2_ready` high at edge N produces `butterfly3_ready` high after edge N+2, with data valid in the same cycle.
- **Throughput.** 1 frame/cycle.
- **Reset values.**
  - All `fft_x*_o` = 0.
  - `butterfly3_ready` = 0.
  - `fft_frame_cnt` = 0.
  - `vA` and stage-A registers = 0.
- **Reset mid-operation.**
  - Any in-flight frame is discarded.
  - No `butterfly3_ready` pulse occurs for it after `rst_n` deasserts.
  - The counter is not incremented.
- **Input during reset.** A `butterfly2_ready` pulse coinciding with `rst_n` low is ignored.
- **Ready/counter relationship.** `fft_frame_cnt` updates on the same edge that raises `butterfly3_ready`. It reads N+1 in the cycle the pulse is visible.

## Configuration
- Macro: `BUTTERFLY3_ROUND_EN`.
- **Defined.**
  - sh(v) = (v + 128) >>> 8, i.e. round half up, applied to t6 and t8 only.
  - t5 and t7 paths are unaffected.
- **Undefined.** sh(v) = v >>> 8 (floor).
- Latency and interface are identical in both builds.

## Test plan
- **Twiddle W1.** All inputs 0 except d6 = (256, 0), one `butterfly2_ready` pulse.
  - Expect `butterfly3_ready` exactly 2 cycles later.
  - Expect x2 = (181, −181) and x6 = (−181, 181); all other outputs 0.
- **Twiddle W2/W3.** d3 = (100, 0), d7 = (10, 20), d4 = (0, 0), d8 = (256, 0).
  - Expect x3 = (120, −10) and x7 = (80, 10).
  - Expect x4 = (−181, −181) and x8 = (181, 181).
- **Rounding.** d6 = (1, 0).
  - Without the macro: x2 = (0, −1).
  - With `BUTTERFLY3_ROUND_EN`: x2 = (1, −1).
- **Streaming.** 3 consecutive `butterfly2_ready` cycles carrying distinct frames (d1 = 1, 2, 3).
  - Expect 3 consecutive `butterfly3_ready` cycles with x1 = 1, 2, 3 in order.
  - Expect `fft_frame_cnt` to step 0→3.
- **Reset mid-flight.** Pulse `butterfly2_ready`, then drop `rst_n` one cycle later.
  - Outputs go to 0 immediately.
  - No ready pulse after release; `fft_frame_cnt` = 0.
- **Counter wrap and overflow.** Drive 256 frames, expecting `fft_frame_cnt` = 0 afterwards. Then drive d1 = 0x7FFFFFFF, d5 = 1, expecting x1 = 0x80000000 (wrap).
